// File: rtl/mat_ctrl_pkg.sv
// mat_ctrl_pkg: shared state encoding, default array size and feed-length helper for the matrix-unit sequencer.
package mat_ctrl_pkg;
  localparam int DIM_DEFAULT = 8;
  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} mat_state_t;
  function automatic int feed_cycles(input int dim);
    return 3 * dim - 2;
  endfunction
endpackage

// File: rtl/mat_unit_ctrl_if.sv
// mat_unit_ctrl_if: execute-stage <-> matrix-unit sequencer signals; master is execute, slave is the sequencer.
interface mat_unit_ctrl_if #(parameter int DIM = mat_ctrl_pkg::DIM_DEFAULT);
  localparam int CNT_W = $clog2(mat_ctrl_pkg::feed_cycles(DIM));
  logic             start_i;
  logic             wr_ab_i;
  logic             rd_c_i;
  logic             stall_o;
  logic             busy_o;
  logic             arr_clr_o;
  logic             arr_shift_en_o;
  logic [CNT_W-1:0] feed_idx_o;
  logic             done_o;
  logic             c_valid_o;
  modport master (output start_i, wr_ab_i, rd_c_i,
                  input  stall_o, busy_o, arr_clr_o, arr_shift_en_o, feed_idx_o, done_o, c_valid_o);
  modport slave  (input  start_i, wr_ab_i, rd_c_i,
                  output stall_o, busy_o, arr_clr_o, arr_shift_en_o, feed_idx_o, done_o, c_valid_o);
endinterface

// File: rtl/mat_feed_counter.sv
// mat_feed_counter: diagonal feed index with synchronous load-to-zero, enable and terminal count at LAST.
module mat_feed_counter #(
  parameter int CNT_W = 5,
  parameter int LAST  = 21
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = load_i ? '0 : en_i ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q;
  assign tc_o  = cnt_q == CNT_W'(LAST);
endmodule

// File: rtl/mat_unit_ctrl.sv
// mat_unit_ctrl: systolic matrix-unit sequencer (IDLE->CLEAR->FEED->DONE) with pipeline stall generation.
// Optional busy-cycle counter is built when MAT_CTRL_PERF_EN is defined.
module mat_unit_ctrl
  import mat_ctrl_pkg::*;
#(
  parameter int DIM = DIM_DEFAULT,
  localparam int CNT_W = $clog2(feed_cycles(DIM))
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  mat_unit_ctrl_if.slave        bus
`ifdef MAT_CTRL_PERF_EN
  ,
  output logic [31:0]           busy_cycles_o
`endif
);
  mat_state_t state_q, state_d;
  logic       c_valid_q, c_valid_d;
  logic       tc;
  logic       in_feed;
  assign in_feed = state_q == FEED;
  mat_feed_counter #(.CNT_W(CNT_W), .LAST(feed_cycles(DIM) - 1)) u_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (!in_feed || tc),
    .en_i    (in_feed),
    .cnt_o   (bus.feed_idx_o),
    .tc_o    (tc)
  );
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = bus.start_i ? CLEAR : IDLE;
      CLEAR:   state_d = FEED;
      FEED:    state_d = tc ? DONE : FEED;
      default: state_d = IDLE;
    endcase
    c_valid_d = (state_q == IDLE && bus.start_i) ? 1'b0 : (state_q == DONE) ? 1'b1 : c_valid_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      c_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_valid_q <= c_valid_d;
    end
  end
  assign bus.busy_o         = state_q != IDLE;
  assign bus.arr_clr_o      = state_q == CLEAR;
  assign bus.arr_shift_en_o = in_feed;
  assign bus.done_o         = state_q == DONE;
  assign bus.c_valid_o      = c_valid_q;
  assign bus.stall_o        = bus.busy_o & (bus.start_i | bus.wr_ab_i | bus.rd_c_i);
`ifdef MAT_CTRL_PERF_EN
  logic [31:0] busy_cycles_q, busy_cycles_d;
  always_comb begin
    busy_cycles_d = (bus.busy_o && busy_cycles_q != '1) ? busy_cycles_q + 32'd1 : busy_cycles_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) busy_cycles_q <= '0;
    else          busy_cycles_q <= busy_cycles_d;
  end
  assign busy_cycles_o = busy_cycles_q;
`endif
endmodule
